// File: rtl/regfile_wb_arbiter_pkg.sv
// ============================================================================
//  Module   : regfile_ctrl_pkg
//  Purpose  : Shared constants and types for the register-file writeback
//             arbiter and its scoreboard.
//  Contents : ADDR_W, DATA_W, NUM_REGS, REG_ZERO, wb_req_t
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_ctrl_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int REG_ZERO = 0;

    // One writeback request as seen by a shared write port.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
// ============================================================================
//  Module   : regfile_wb_arbiter_if
//  Purpose  : Bundles the writeback sources, register-file write port,
//             issue reservation and decode hazard signals.
//  Modports : slave  - arbiter side
//             master - execute/issue/decode side
//  Optional : REGFILE_WB_BYPASS_EN adds fwd_rs1_en, fwd_rs2_en, fwd_data
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface regfile_wb_arbiter_if #(
    parameter int NUM_SRC = 2,
    parameter int ADDR_W  = regfile_ctrl_pkg::ADDR_W,
    parameter int DATA_W  = regfile_ctrl_pkg::DATA_W
);
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [NUM_SRC*ADDR_W-1:0] src_rd;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic                      rf_we;
    logic [ADDR_W-1:0]         rf_waddr;
    logic [DATA_W-1:0]         rf_wdata;
    logic                      iss_valid;
    logic [ADDR_W-1:0]         iss_rd;
    logic                      iss_ready;
    logic [ADDR_W-1:0]         chk_rs1;
    logic [ADDR_W-1:0]         chk_rs2;
    logic                      hazard;
`ifdef REGFILE_WB_BYPASS_EN
    logic                      fwd_rs1_en;
    logic                      fwd_rs2_en;
    logic [DATA_W-1:0]         fwd_data;
`endif

    modport slave (
        input  src_valid, src_rd, src_data, iss_valid, iss_rd, chk_rs1, chk_rs2,
        output src_ready, rf_we, rf_waddr, rf_wdata, iss_ready, hazard
`ifdef REGFILE_WB_BYPASS_EN
        , output fwd_rs1_en, fwd_rs2_en, fwd_data
`endif
    );

    modport master (
        output src_valid, src_rd, src_data, iss_valid, iss_rd, chk_rs1, chk_rs2,
        input  src_ready, rf_we, rf_waddr, rf_wdata, iss_ready, hazard
`ifdef REGFILE_WB_BYPASS_EN
        , input fwd_rs1_en, fwd_rs2_en, fwd_data
`endif
    );

endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin arbiter. Combinational one-hot grant; the priority
//             pointer moves to grant+1 (mod N) on every grant.
//  Ports    : clk, rst (async, active-high)
//             i_req   [N-1:0] requests
//             o_grant [N-1:0] one-hot grant, zero when nothing requests
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic [N-1:0] i_req,
    output logic      [N-1:0] o_grant
);

    localparam int c_ptr_w = (N > 1) ? $clog2(N) : 1;

    logic [c_ptr_w-1:0] r_ptr;
    logic [c_ptr_w-1:0] w_next_ptr;
    logic [N-1:0]       w_grant;
    logic               w_found;

    // Scan offsets 0..N-1 from the pointer; the first requester wins.
    always_comb begin
        w_grant    = '0;
        w_found    = 1'b0;
        w_next_ptr = r_ptr;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!w_found && i_req[i] && (i == ((int'(r_ptr) + k) % N))) begin
                    w_grant[i] = 1'b1;
                    w_found    = 1'b1;
                    w_next_ptr = c_ptr_w'((i + 1) % N);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_next_ptr;
        end
    end

    assign o_grant = w_grant;

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Shares the register file write port among NUM_SRC writeback
//             sources, tracks per-register reservations and flags decode
//             operand hazards.
//  Ports    : clk, rst (async, active-high)
//             bus (regfile_wb_arbiter_if.slave):
//               src_valid/src_ready/src_rd/src_data  writeback sources
//               rf_we/rf_waddr/rf_wdata              register file WE3/A3/WD3
//               iss_valid/iss_rd/iss_ready           destination reservation
//               chk_rs1/chk_rs2/hazard               decode operand check
//  Optional : REGFILE_WB_BYPASS_EN - forwards the committing write to decode
//             (fwd_rs1_en, fwd_rs2_en, fwd_data) and removes that stall.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int ADDR_W  = regfile_ctrl_pkg::ADDR_W,
    parameter int DATA_W  = regfile_ctrl_pkg::DATA_W
) (
    input  wire logic           clk,
    input  wire logic           rst,
    regfile_wb_arbiter_if.slave bus
);

    import regfile_ctrl_pkg::REG_ZERO;

    localparam int                c_num_regs = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_x0       = ADDR_W'(REG_ZERO);

    logic [NUM_SRC-1:0]    w_req;
    logic [NUM_SRC-1:0]    w_grant;
    logic                  w_any;
    logic [ADDR_W-1:0]     w_sel_rd;
    logic [DATA_W-1:0]     w_sel_data;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_waddr;
    logic [DATA_W-1:0]     r_wdata;
    logic [c_num_regs-1:0] r_busy;
    logic                  w_iss_ready;
    logic                  w_busy1;
    logic                  w_busy2;

    // No grants are handed out while reset is held.
    assign w_req = rst ? '0 : bus.src_valid;

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req   (w_req),
        .o_grant (w_grant)
    );

    assign bus.src_ready = w_grant;
    assign w_any         = |w_grant;

    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_grant[i]) begin
                w_sel_rd   = bus.src_rd[i*ADDR_W +: ADDR_W];
                w_sel_data = bus.src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Write stage: a write granted to x0 is consumed but never enables WE3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_any && (w_sel_rd != c_x0);
            if (w_any) begin
                r_waddr <= w_sel_rd;
                r_wdata <= w_sel_data;
            end
        end
    end

    assign bus.rf_we    = r_we;
    assign bus.rf_waddr = r_waddr;
    assign bus.rf_wdata = r_wdata;

    // A busy register is refused even while it commits: one producer at a time.
    assign w_iss_ready   = (bus.iss_rd == c_x0) || !r_busy[bus.iss_rd];
    assign bus.iss_ready = w_iss_ready;

    // Set is applied after clear so a same-edge set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (r_we) begin
                r_busy[r_waddr] <= 1'b0;
            end
            if (bus.iss_valid && w_iss_ready && (bus.iss_rd != c_x0)) begin
                r_busy[bus.iss_rd] <= 1'b1;
            end
        end
    end

    assign w_busy1 = (bus.chk_rs1 != c_x0) && r_busy[bus.chk_rs1];
    assign w_busy2 = (bus.chk_rs2 != c_x0) && r_busy[bus.chk_rs2];

`ifdef REGFILE_WB_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;

    assign w_fwd1         = r_we && (r_waddr == bus.chk_rs1) && (bus.chk_rs1 != c_x0);
    assign w_fwd2         = r_we && (r_waddr == bus.chk_rs2) && (bus.chk_rs2 != c_x0);
    assign bus.fwd_rs1_en = w_fwd1;
    assign bus.fwd_rs2_en = w_fwd2;
    assign bus.fwd_data   = r_wdata;
    assign bus.hazard     = (w_busy1 && !w_fwd1) || (w_busy2 && !w_fwd2);
`else
    // Without forwarding, a committing register is still unreadable this cycle.
    assign bus.hazard = w_busy1 || w_busy2;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none

module tb_regfile_wb_arbiter;

    localparam int NS = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NUM_SRC(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

    regfile_wb_arbiter #(.NUM_SRC(NS), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    int            m_ptr;
    bit [31:0]     m_busy;
    bit            m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    bit            p_valid [NS];
    logic [AW-1:0] p_rd    [NS];
    logic [DW-1:0] p_data  [NS];
    exp_t          exp_q   [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < NS; i++) begin
            bus.src_valid[i]            = p_valid[i];
            bus.src_rd[i*AW +: AW]      = p_rd[i];
            bus.src_data[i*DW +: DW]    = p_data[i];
        end
    endtask

    task automatic set_iss(input bit v, input int rd, input int rs1, input int rs2);
        bus.iss_valid = v;
        bus.iss_rd    = AW'(rd);
        bus.chk_rs1   = AW'(rs1);
        bus.chk_rs2   = AW'(rs2);
    endtask

    task automatic pend(input int i, input int rd, input logic [DW-1:0] d);
        p_valid[i] = 1'b1;
        p_rd[i]    = AW'(rd);
        p_data[i]  = d;
    endtask

    // One clock cycle: apply inputs, check combinational outputs against the
    // model at the falling edge, queue the expected registered write.
    task automatic step();
        int   g;
        bit   exp_iss, hz1, hz2;
        exp_t e;
        drive_srcs();
        @(negedge clk);
        g = -1;
        for (int k = 0; k < NS; k++)
            if (g < 0 && p_valid[(m_ptr + k) % NS]) g = (m_ptr + k) % NS;
        check("src_ready", bus.src_ready, (g < 0) ? 64'd0 : (64'd1 << g));
        exp_iss = (bus.iss_rd == 0) || !m_busy[bus.iss_rd];
        check("iss_ready", bus.iss_ready, exp_iss);
        hz1 = (bus.chk_rs1 != 0) && m_busy[bus.chk_rs1];
        hz2 = (bus.chk_rs2 != 0) && m_busy[bus.chk_rs2];
`ifdef REGFILE_WB_BYPASS_EN
        begin
            bit f1, f2;
            f1 = m_we && (m_waddr == bus.chk_rs1) && (bus.chk_rs1 != 0);
            f2 = m_we && (m_waddr == bus.chk_rs2) && (bus.chk_rs2 != 0);
            check("fwd_rs1_en", bus.fwd_rs1_en, f1);
            check("fwd_rs2_en", bus.fwd_rs2_en, f2);
            if (f1 || f2) check("fwd_data", bus.fwd_data, m_wdata);
            hz1 = hz1 && !f1;
            hz2 = hz2 && !f2;
        end
`endif
        check("hazard", bus.hazard, hz1 || hz2);
        if (m_we) m_busy[m_waddr] = 1'b0;
        if (bus.iss_valid && exp_iss && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
        if (g >= 0) begin
            e.we       = (p_rd[g] != 0);
            e.addr     = p_rd[g];
            e.data     = p_data[g];
            m_waddr    = p_rd[g];
            m_wdata    = p_data[g];
            p_valid[g] = 1'b0;
            m_ptr      = (g + 1) % NS;
        end else begin
            e.we   = 1'b0;
            e.addr = m_waddr;
            e.data = m_wdata;
        end
        m_we = e.we;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset applied between clock edges; outputs must clear at once.
    task automatic do_reset(input int cycles);
        drive_srcs();
        rst = 1'b1;
        exp_q.delete();
        m_ptr  = 0;
        m_busy = '0;
        m_we   = 1'b0;
        #1;
        check("rst_rf_we", bus.rf_we, 1'b0);
        check("rst_src_ready", bus.src_ready, '0);
        check("rst_hazard", bus.hazard, 1'b0);
        check("rst_iss_ready", bus.iss_ready, 1'b1);
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare the registered write port after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rf_we", bus.rf_we, e.we);
                if (e.we) begin
                    check("rf_waddr", bus.rf_waddr, e.addr);
                    check("rf_wdata", bus.rf_wdata, e.data);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NS; i++) begin
            p_valid[i] = 1'b0;
            p_rd[i]    = '0;
            p_data[i]  = '0;
        end
        m_waddr = '0;
        m_wdata = '0;
        set_iss(1'b0, 0, 0, 0);
        drive_srcs();
        #1;

        // Reset with src0 already pending, then its first write
        pend(0, 5, 32'h0000_000A);
        do_reset(2);
        step();
        step();

        // Round robin with both sources holding
        for (int c = 0; c < 4; c++) begin
            if (!p_valid[0]) pend(0, 5, 32'h0000_0011 + c);
            if (!p_valid[1]) pend(1, 6, 32'h0000_0022 + c);
            step();
        end
        step();
        step();

        // Write to x0 is consumed but not committed
        pend(1, 0, 32'hDEAD_BEEF);
        step();
        step();

        // Reservation, refusal, commit and release of x6
        set_iss(1'b1, 6, 0, 0);
        step();
        set_iss(1'b1, 6, 6, 0);
        step();
        set_iss(1'b0, 0, 6, 0);
        pend(0, 6, 32'h0000_000B);
        step();
        step();
        step();
        step();

        // Reservation wiped by reset while operand is being checked
        set_iss(1'b1, 9, 9, 0);
        step();
        set_iss(1'b0, 0, 9, 0);
        step();
        do_reset(1);
        step();

        // Randomised traffic
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < NS; i++)
                if (!p_valid[i] && $urandom_range(0, 1) == 1)
                    pend(i, $urandom_range(0, 7), $urandom);
            set_iss($urandom_range(0, 1) == 1, $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7));
            if (c == 250) do_reset(1);
            step();
        end

        set_iss(1'b0, 0, 0, 0);
        for (int i = 0; i < NS; i++) p_valid[i] = 1'b0;
        step();
        step();
        repeat (2) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
